// File: rtl/sipo_deser_pkg.sv
// Shared types and constants for the SIPO receiver slice.
package sipo_pkg;

    localparam int SIPO_WIDTH_DEF = 4;
    localparam int CNT_W_DEF      = $clog2(SIPO_WIDTH_DEF);

    // Output register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hs_state_e;

    // Bit-count width for a given word size.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input, parallel output handshake and status bundle of the SIPO receiver.
interface sipo_deser_if import sipo_pkg::*; #(
    parameter int WIDTH = SIPO_WIDTH_DEF
);
    logic                      serial_in;
    logic                      shift_en;
    logic                      frame_start;
    logic                      out_ready;
    logic                      overrun_clr;
    logic [WIDTH-1:0]          parallel_out;
    logic                      out_valid;
    logic                      overrun;
    logic [cnt_w(WIDTH)-1:0]   bit_cnt;

    modport master (
        output serial_in, shift_en, frame_start, out_ready, overrun_clr,
        input  parallel_out, out_valid, overrun, bit_cnt
    );

    modport slave (
        input  serial_in, shift_en, frame_start, out_ready, overrun_clr,
        output parallel_out, out_valid, overrun, bit_cnt
    );
endinterface

// File: rtl/sipo_deser_bit_counter.sv
// Mod-WIDTH bit counter; clear wins over increment, but a same-cycle increment counts as bit 0.
module sipo_bit_counter import sipo_pkg::*; #(
    parameter int WIDTH = SIPO_WIDTH_DEF,
    localparam int CW   = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          wrap
);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = inc ? CW'(1) : '0;
        else if (inc)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign wrap = inc & ~clr & (cnt_q == LAST);
endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out receiver: shift register, registered output word with valid/ready, sticky overrun.
module sipo_deser import sipo_pkg::*; #(
    parameter int WIDTH     = SIPO_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    sipo_deser_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [WIDTH-1:0] base, shifted;
    logic [WIDTH-1:0] pout_q, pout_d;
    hs_state_e        state_q, state_d;
    logic             ovr_q, ovr_d;
    logic [CW-1:0]    cnt;
    logic             wrap;

    sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.frame_start),
        .inc   (bus.shift_en),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    // A frame restart drops the partial word before this cycle's bit goes in.
    always_comb begin
        base = bus.frame_start ? '0 : shift_reg_q;
        if (MSB_FIRST)
            shifted = {base[WIDTH-2:0], bus.serial_in};
        else
            shifted = {bus.serial_in, base[WIDTH-1:1]};
        shift_reg_d = bus.shift_en ? shifted : shift_reg_q;
    end

    always_comb begin
        state_d = state_q;
        pout_d  = pout_q;
        ovr_d   = ovr_q & ~bus.overrun_clr;
        case (state_q)
            EMPTY: begin
                if (wrap) begin
                    state_d = FULL;
                    pout_d  = shifted;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    if (wrap) pout_d = shifted;
                    else      state_d = EMPTY;
                end else if (wrap) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg_q <= '0;
            pout_q      <= '0;
            state_q     <= EMPTY;
            ovr_q       <= 1'b0;
        end else begin
            shift_reg_q <= shift_reg_d;
            pout_q      <= pout_d;
            state_q     <= state_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.parallel_out = pout_q;
    assign bus.out_valid    = (state_q == FULL);
    assign bus.overrun      = ovr_q;
    assign bus.bit_cnt      = cnt;
endmodule
